// File: rtl/operand_pair_collector_pkg.sv
// Shared types and constants for the operand pair collector.
package operand_collector_pkg;

    typedef enum logic {
        WAIT_A = 1'b0,
        WAIT_B = 1'b1
    } collector_state_t;

    localparam int PAIR_WIDTH_DEFAULT = 1;
    localparam int PAIR_DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic [PAIR_WIDTH_DEFAULT-1:0] a;
        logic [PAIR_WIDTH_DEFAULT-1:0] b;
    } pair_t;

    // Occupancy counter needs one bit more than the pointers to represent "full".
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int COUNT_WIDTH_DEFAULT = count_width(PAIR_DEPTH_DEFAULT);

endpackage

// File: rtl/operand_pair_collector_if.sv
// Operand input stream plus aligned-pair output stream of the collector.
interface operand_pair_collector_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
);
    import operand_collector_pkg::*;

    localparam int CW = count_width(DEPTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [CW-1:0]    count;

    modport master (
        output in_valid, in_data, abort, out_ready,
        input  in_ready, out_valid, out_a, out_b, count
    );

    modport slave (
        input  in_valid, in_data, abort, out_ready,
        output in_ready, out_valid, out_a, out_b, count
    );

endinterface

// File: rtl/operand_pair_collector_pair_fifo.sv
// Small synchronous FIFO holding completed operand pairs; head is a register read.
module pair_fifo
    import operand_collector_pkg::*;
#(
    parameter int DW    = 2,
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = count_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [DEPTH-1:0][DW-1:0] mem;
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic                     do_push;
    logic                     do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage cleared on reset so the head reads zero before the first push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally; count tracks occupancy independently of them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst) count <= CW'(DEPTH));

endmodule

// File: rtl/operand_pair_collector.sv
// Pairs A/B operands arriving serially and queues aligned pairs for the compute stage.
module operand_pair_collector
    import operand_collector_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2,
    localparam int CW   = count_width(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    operand_pair_collector_if.slave  bus
);

    collector_state_t   state, state_nxt;
    logic [WIDTH-1:0]   a_hold;
    logic               fifo_full;
    logic               fifo_empty;
    logic [2*WIDTH-1:0] fifo_head;
    logic [CW-1:0]      fifo_count;
    logic               take_a;
    logic               push;
    logic               pop;

    // B is held off only by registered fullness (or abort), never by out_ready.
    always_comb begin
        bus.in_ready = 1'b1;
        if (state == WAIT_B) bus.in_ready = !fifo_full && !bus.abort;
    end

    assign take_a = (state == WAIT_A) && bus.in_valid;
    assign push   = (state == WAIT_B) && bus.in_valid && bus.in_ready;
    assign pop    = bus.out_valid && bus.out_ready;

    // Next-state: A moves to WAIT_B, a B push or an abort returns to WAIT_A.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_A:  if (take_a) state_nxt = WAIT_B;
            WAIT_B:  if (bus.abort || push) state_nxt = WAIT_A;
            default: state_nxt = WAIT_A;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= WAIT_A;
        else      state <= state_nxt;
    end

    // Partial A: captured on A transfer, cleared when aborted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                a_hold <= '0;
        else if (take_a)                         a_hold <= bus.in_data;
        else if (state == WAIT_B && bus.abort)   a_hold <= '0;
    end

    pair_fifo #(
        .DW    (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({a_hold, bus.in_data}),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_a     = fifo_head[2*WIDTH-1:WIDTH];
    assign bus.out_b     = fifo_head[WIDTH-1:0];
    assign bus.count     = fifo_count;

endmodule

// File: tb/tb_operand_pair_collector.sv
// Directed bench: WIDTH=1 smoke instance plus WIDTH=8/DEPTH=2 main instance.
module tb_operand_pair_collector;

    logic clk;
    logic rst;

    int n_chk  = 0;
    int n_pass = 0;

    operand_pair_collector_if #(.WIDTH(1), .DEPTH(2)) b1 ();
    operand_pair_collector_if #(.WIDTH(8), .DEPTH(2)) b8 ();

    operand_pair_collector #(.WIDTH(1), .DEPTH(2)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
    operand_pair_collector #(.WIDTH(8), .DEPTH(2)) u_dut8 (.clk(clk), .rst(rst), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Offer one operand on the 8-bit instance and hold it until transferred.
    task automatic put(input logic [7:0] d);
        int n;
        n = 0;
        b8.in_valid = 1'b1;
        b8.in_data  = d;
        #1;
        while (!b8.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("put_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
    endtask

    task automatic head_is(input string tag, input logic [7:0] a, input logic [7:0] b);
        chk({tag, "_vld"}, 32'(b8.out_valid), 32'd1);
        chk({tag, "_ab"}, {16'd0, b8.out_a, b8.out_b}, {16'd0, a, b});
    endtask

    logic [7:0] ops [100];

    initial begin
        int idx, got, maxc, cyc;
        rst = 1'b0;
        b1.in_valid = 0; b1.in_data = '0; b1.abort = 0; b1.out_ready = 0;
        b8.in_valid = 0; b8.in_data = '0; b8.abort = 0; b8.out_ready = 0;
        #12;
        chk("rst_vld",   32'(b8.out_valid), 32'd0);
        chk("rst_cnt",   32'(b8.count), 32'd0);
        chk("rst_ab",    {16'd0, b8.out_a, b8.out_b}, 32'd0);
        chk("rst_ab1",   {30'd0, b1.out_a, b1.out_b}, 32'd0);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_rdy",   32'(b8.in_ready), 32'd1);

        // WIDTH=1 smoke: A=1, B=0, downstream always ready.
        b1.out_ready = 1'b1;
        b1.in_valid  = 1'b1; b1.in_data = 1'b1;
        @(posedge clk); #1;
        b1.in_data = 1'b0;
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
        chk("w1_vld", 32'(b1.out_valid), 32'd1);
        chk("w1_ab",  {30'd0, b1.out_a, b1.out_b}, 32'b10);
        chk("w1_cnt", 32'(b1.count), 32'd1);
        @(posedge clk); #1;
        chk("w1_cnt0", 32'(b1.count), 32'd0);
        chk("w1_vld0", 32'(b1.out_valid), 32'd0);
        b1.out_ready = 1'b0;

        // Fill to DEPTH with downstream stalled; A still accepted when full.
        put(8'h11); put(8'h22);
        chk("fill_cnt1", 32'(b8.count), 32'd1);
        put(8'h33); put(8'h44);
        chk("fill_cnt2", 32'(b8.count), 32'd2);
        put(8'h55);
        b8.in_valid = 1'b1; b8.in_data = 8'h66;
        #1;
        chk("full_rdy", 32'(b8.in_ready), 32'd0);
        head_is("full_head", 8'h11, 8'h22);
        b8.out_ready = 1'b1;
        @(posedge clk); #1;
        b8.out_ready = 1'b0;
        chk("pop1_cnt", 32'(b8.count), 32'd1);
        head_is("pop1_head", 8'h33, 8'h44);
        chk("pop1_rdy", 32'(b8.in_ready), 32'd1);
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        chk("stallb_cnt", 32'(b8.count), 32'd2);
        b8.out_ready = 1'b1;
        head_is("drain1", 8'h33, 8'h44);
        @(posedge clk); #1;
        head_is("drain2", 8'h55, 8'h66);
        @(posedge clk); #1;
        chk("drain_empty", 32'(b8.out_valid), 32'd0);
        b8.out_ready = 1'b0;

        // Abort in WAIT_B discards 0xAA and blocks the B on that cycle.
        put(8'hAA);
        b8.in_valid = 1'b1; b8.in_data = 8'hBB; b8.abort = 1'b1;
        #1;
        chk("abort_rdy", 32'(b8.in_ready), 32'd0);
        @(posedge clk); #1;
        b8.abort = 1'b0; b8.in_valid = 1'b0;
        chk("abort_cnt", 32'(b8.count), 32'd0);
        put(8'h01); put(8'h02);
        chk("abort_cnt1", 32'(b8.count), 32'd1);
        head_is("abort_pair", 8'h01, 8'h02);
        b8.out_ready = 1'b1;
        @(posedge clk); #1;
        b8.out_ready = 1'b0;
        chk("abort_after", 32'(b8.out_valid), 32'd0);

        // Abort in WAIT_A has no effect on the A transfer.
        b8.abort = 1'b1;
        b8.in_valid = 1'b1; b8.in_data = 8'h77;
        #1;
        chk("aborta_rdy", 32'(b8.in_ready), 32'd1);
        @(posedge clk); #1;
        b8.abort = 1'b0; b8.in_valid = 1'b0;
        put(8'h88);
        head_is("aborta_pair", 8'h77, 8'h88);
        b8.out_ready = 1'b1;
        @(posedge clk); #1;
        b8.out_ready = 1'b0;

        // Continuous streaming of 100 operands with downstream always ready.
        for (int i = 0; i < 100; i++) ops[i] = 8'($urandom_range(0, 255));
        idx = 0; got = 0; maxc = 0; cyc = 0;
        b8.out_ready = 1'b1;
        while (got < 50 && cyc < 400) begin
            b8.in_valid = (idx < 100);
            b8.in_data  = (idx < 100) ? ops[idx] : 8'h00;
            #1;
            if (int'(b8.count) > maxc) maxc = int'(b8.count);
            if (b8.out_valid) begin
                chk("stream_pair", {16'd0, b8.out_a, b8.out_b}, {16'd0, ops[2*got], ops[2*got+1]});
                got++;
            end
            if (b8.in_valid && b8.in_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        b8.in_valid = 1'b0; b8.out_ready = 1'b0;
        chk("stream_pairs", 32'(got), 32'd50);
        chk("stream_ops",   32'(idx), 32'd100);
        chk("stream_maxc",  32'(maxc), 32'd1);
        chk("stream_cnt0",  32'(b8.count), 32'd0);

        // Async reset with two pairs queued and an A held.
        put(8'hC1); put(8'hC2); put(8'hC3); put(8'hC4); put(8'hC5);
        chk("mid_cnt2", 32'(b8.count), 32'd2);
        #2 rst = 1'b0;
        #1;
        chk("mid_vld", 32'(b8.out_valid), 32'd0);
        chk("mid_cnt", 32'(b8.count), 32'd0);
        chk("mid_ab",  {16'd0, b8.out_a, b8.out_b}, 32'd0);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        put(8'hD1); put(8'hD2);
        chk("post_cnt", 32'(b8.count), 32'd1);
        head_is("post_pair", 8'hD1, 8'hD2);
        b8.out_ready = 1'b1;
        @(posedge clk); #1;
        b8.out_ready = 1'b0;

        // Simultaneous push/pop at count==DEPTH-1, twice, crossing the wrap.
        put(8'hE1); put(8'hE2);
        put(8'hE3);
        b8.in_valid = 1'b1; b8.in_data = 8'hE4; b8.out_ready = 1'b1;
        #1;
        chk("pp1_rdy", 32'(b8.in_ready), 32'd1);
        @(posedge clk); #1;
        b8.in_valid = 1'b0; b8.out_ready = 1'b0;
        chk("pp1_cnt", 32'(b8.count), 32'd1);
        head_is("pp1_head", 8'hE3, 8'hE4);
        put(8'hE5);
        b8.in_valid = 1'b1; b8.in_data = 8'hE6; b8.out_ready = 1'b1;
        @(posedge clk); #1;
        b8.in_valid = 1'b0; b8.out_ready = 1'b0;
        chk("pp2_cnt", 32'(b8.count), 32'd1);
        head_is("pp2_head", 8'hE5, 8'hE6);
        b8.out_ready = 1'b1;
        @(posedge clk); #1;
        b8.out_ready = 1'b0;
        chk("pp_empty", 32'(b8.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
